reg_load_fifo: RTL and testbench

- Upstream feeder for the 32-bit enabled holding register. It drives that register's din/en pair.
- Buffers words from a valid/ready producer in a small synchronous FIFO.
- Presents one word per cycle to the register with a single-cycle en pulse per word.
- A hold input lets downstream logic freeze loading without losing data.

---
 rtl/reg_load_fifo.sv | 79 +++++++
 tb/tb_reg_load_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/reg_load_fifo.sv
// reg_load_fifo: upstream feeder for a WIDTH-bit enabled holding register.
// Buffers words from a valid/ready producer in a DEPTH-entry synchronous FIFO
// and pops at most one word per cycle onto a registered din/en pair. Each
// popped word produces exactly one cycle of en.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   wr_data   producer word
//   wr_valid  producer offers wr_data
//   wr_ready  FIFO accepts this cycle (= !full, combinational)
//   hold      suppresses the pop of this cycle
//   din       registered word to the holding register
//   en        registered one-cycle load strobe per popped word
//   count     occupancy 0..DEPTH
//   full      count == DEPTH
//   empty     count == 0
module reg_load_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             hold,
  output logic [WIDTH-1:0] din,
  output logic             en,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  // Full/empty come from the occupancy count, so pointer equality is never
  // ambiguous after wrap-around.
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign wr_ready = !full;

  // Both decisions use pre-edge state: a full FIFO refuses a push even when a
  // pop frees a slot on the same edge, and an empty FIFO never bypasses.
  assign push = wr_valid && wr_ready;
  assign pop  = !empty && !hold;

  // Storage needs no reset; its contents are only read behind count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      din    <= '0;
      en     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        din    <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      // din holds its last word when idle; only the strobe drops.
      en <= pop;
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_load_fifo.sv
module tb_reg_load_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] wr_data = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic             hold = 1'b0;
  logic [WIDTH-1:0] din;
  logic             en;
  logic [AW:0]      count;
  logic             full;
  logic             empty;

  int n_chk  = 0;
  int n_fail = 0;

  reg_load_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .hold(hold), .din(din), .en(en), .count(count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one rising edge, then settle 1 ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".count"}, 32'(count), 0);
    chk({tag, ".empty"}, 32'(empty), 1);
    chk({tag, ".full"}, 32'(full), 0);
    chk({tag, ".wr_ready"}, 32'(wr_ready), 1);
    chk({tag, ".en"}, 32'(en), 0);
  endtask

  task automatic push_word(input logic [31:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    // 1: reset, then idle
    #2 reset = 1'b0;
    #1;
    chk_idle("rst");
    chk("rst.din", din, 0);
    tick();
    chk_idle("rst_clk");
    #3 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("idle");
      chk("idle.din", din, 0);
    end

    // 2: single word latency
    push_word(32'h11);
    chk("t2.e1.en", 32'(en), 0);
    chk("t2.e1.count", 32'(count), 1);
    tick();
    chk("t2.e2.en", 32'(en), 1);
    chk("t2.e2.din", din, 32'h11);
    chk("t2.e2.count", 32'(count), 0);
    tick();
    chk("t2.e3.en", 32'(en), 0);
    chk("t2.e3.din", din, 32'h11);

    // 3: fill under hold, refuse fifth, drain
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
    chk("t3.count", 32'(count), 4);
    chk("t3.full", 32'(full), 1);
    chk("t3.wr_ready", 32'(wr_ready), 0);
    chk("t3.en_held", 32'(en), 0);
    push_word(32'hA4);
    chk("t3.refuse.count", 32'(count), 4);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3.drain.en", 32'(en), 1);
      chk("t3.drain.din", din, 32'hA0 + 32'(i));
      chk("t3.drain.count", 32'(count), 32'(3 - i));
    end
    chk("t3.empty", 32'(empty), 1);
    tick();
    chk("t3.post.en", 32'(en), 0);
    chk("t3.post.din", din, 32'hA3);

    // 4: streaming, one word per cycle
    for (int k = 1; k <= 10; k++) begin
      wr_data  = 32'(k);
      wr_valid = 1'b1;
      tick();
      chk("t4.count", 32'(count), 1);
      if (k == 1) chk("t4.first.en", 32'(en), 0);
      else begin
        chk("t4.en", 32'(en), 1);
        chk("t4.din", din, 32'(k - 1));
      end
    end
    wr_valid = 1'b0;
    tick();
    chk("t4.last.en", 32'(en), 1);
    chk("t4.last.din", din, 10);
    chk("t4.last.count", 32'(count), 0);
    tick();
    chk("t4.end.en", 32'(en), 0);

    // 5: full with simultaneous push and pop
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'hB0 + 32'(i));
    chk("t5.full", 32'(full), 1);
    hold     = 1'b0;
    wr_data  = 32'hB4;
    wr_valid = 1'b1;
    tick();
    chk("t5.e1.din", din, 32'hB0);
    chk("t5.e1.count", 32'(count), 3);
    chk("t5.e1.wr_ready", 32'(wr_ready), 1);
    tick();
    chk("t5.e2.din", din, 32'hB1);
    chk("t5.e2.count", 32'(count), 3);
    wr_data = 32'hB5;
    tick();
    chk("t5.e3.din", din, 32'hB2);
    chk("t5.e3.count", 32'(count), 3);
    wr_valid = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      tick();
      chk("t5.drain.en", 32'(en), 1);
      chk("t5.drain.din", din, 32'hB0 + 32'(i));
    end
    tick();
    chk("t5.end.en", 32'(en), 0);
    chk("t5.end.empty", 32'(empty), 1);

    // 6: asynchronous reset mid-operation
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'hC0 + 32'(i));
    hold = 1'b0;
    tick();
    chk("t6.pre.en", 32'(en), 1);
    chk("t6.pre.din", din, 32'hC0);
    chk("t6.pre.count", 32'(count), 3);
    #2 reset = 1'b0;
    #1;
    chk_idle("t6.rst");
    chk("t6.rst.din", din, 0);
    #1 reset = 1'b1;
    push_word(32'h5);
    chk("t6.e1.en", 32'(en), 0);
    chk("t6.e1.count", 32'(count), 1);
    tick();
    chk("t6.e2.en", 32'(en), 1);
    chk("t6.e2.din", din, 32'h5);
    tick();
    chk("t6.e3.en", 32'(en), 0);
    chk("t6.e3.empty", 32'(empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
